// File: rtl/aes_word_loader.sv
// Word-serial to block-parallel input stage of the Rijndael datapath.
// Packs WORD_W-bit words MSB-first into a BLOCK_W-bit block behind valid/ready.
module aes_word_loader #(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic               err
);

  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BLOCK_W-1:0]   data_q, data_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;

  logic accept;
  logic drain;
  logic close;

  // out_ready -> in_ready is the only combinational path through the block.
  assign in_ready = (state_q == FILL) | out_ready;
  assign accept   = in_valid & in_ready;
  assign drain    = (state_q == FULL) & out_ready;
  assign close    = accept & (in_last | (cnt_q == LAST_IDX));

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = err_q;

    if (clr) begin
      state_d = FILL;
      cnt_d   = '0;
      data_d  = '0;
      last_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (accept) begin
        // The first word of a block wipes the previous block's contents.
        if (cnt_q == '0) data_d = '0;
        for (int k = 0; k < NWORDS; k++) begin
          if (cnt_q == CNT_W'(k)) data_d[BLOCK_W-1-k*WORD_W -: WORD_W] = in_data;
        end
        cnt_d = close ? '0 : cnt_q + 1'b1;
      end

      if (close) begin
        state_d = FULL;
        last_d  = in_last;
        if (cnt_q != LAST_IDX) err_d = 1'b1;
      end else if (drain) begin
        state_d = FILL;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the data register
  // is reset because out_data must read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign err       = err_q;

endmodule
